// File: rtl/panel_sequencer_if.sv
// -----------------------------------------------------------------------------
// panel_sequencer_if
//
// CPU-side bus between the front-panel sequencer and the core: the read-mux
// jam path, the CPU clock-enable gate and the memory write strobe.
//
//   cpu_rd     CPU -> panel  single-cycle strobe when the CPU samples its data in
//   cpu_sync   CPU -> panel  SYNC, high at the start of every machine cycle
//   jam_en     panel -> CPU  read mux selects jam_data over memory
//   jam_data   panel -> CPU  byte to jam
//   cpu_run    panel -> CPU  gates the CPU clock enable while paused
//   mem_we     panel -> mem  one-cycle write strobe at the current CPU address
//   mem_wdata  panel -> mem  write data
//
// master: the sequencer. slave: the CPU / memory side.
// -----------------------------------------------------------------------------
interface panel_sequencer_if;
  logic       cpu_rd;
  logic       cpu_sync;
  logic       jam_en;
  logic [7:0] jam_data;
  logic       cpu_run;
  logic       mem_we;
  logic [7:0] mem_wdata;

  modport master (
    input  cpu_rd, cpu_sync,
    output jam_en, jam_data, cpu_run, mem_we, mem_wdata
  );

  modport slave (
    output cpu_rd, cpu_sync,
    input  jam_en, jam_data, cpu_run, mem_we, mem_wdata
  );
endinterface

// File: rtl/panel_sequencer.sv
// -----------------------------------------------------------------------------
// panel_sequencer
//
// Front-panel operation sequencer for the Altair core. Debounced switch pulses
// (EXAMINE, EXAMINE NEXT, DEPOSIT, DEPOSIT NEXT, RESET) are queued as pending
// requests and executed one at a time by jamming opcode bytes onto the CPU
// data input and strobing the memory write path.
//
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   pause               run/stop switch; high = stopped, requests honoured
//   *_pb                single-cycle debounced press pulses
//   data_sw, addr_sw    low address / deposit data, high address switches
//   bus (master)        CPU / memory bus, see panel_sequencer_if
//   busy                a sequence is active
//   err                 sticky timeout flag, cleared by reset or RESET grant
//
// All outputs are registered: they are computed from the next-state values so
// that they line up with the state register.
// -----------------------------------------------------------------------------
module panel_sequencer #(
  parameter logic [15:0] TIMEOUT = 16'hFFFF,
  parameter logic [7:0]  JMP_OP  = 8'hC3,
  parameter logic [7:0]  NOP_OP  = 8'h00
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     pause,
  input  logic                     examine_pb,
  input  logic                     examine_next_pb,
  input  logic                     deposit_pb,
  input  logic                     deposit_next_pb,
  input  logic                     reset_pb,
  input  logic [7:0]               data_sw,
  input  logic [7:0]               addr_sw,
  panel_sequencer_if.master        bus,
  output logic                     busy,
  output logic                     err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_JAM,
    S_WAIT_SYNC,
    S_WRITE,
    S_DONE
  } state_t;

  typedef enum logic [2:0] {
    OP_RESET,
    OP_EXAMINE,
    OP_DEPOSIT_NEXT,
    OP_EXAMINE_NEXT,
    OP_DEPOSIT
  } op_t;

  // Pending bit positions; the highest set bit wins arbitration.
  localparam int unsigned REQ_DEPOSIT      = 0;
  localparam int unsigned REQ_EXAMINE_NEXT = 1;
  localparam int unsigned REQ_DEPOSIT_NEXT = 2;
  localparam int unsigned REQ_EXAMINE      = 3;
  localparam int unsigned REQ_RESET        = 4;

  state_t      state_q, state_d;
  op_t         op_q, op_d;
  logic [4:0]  pending_q, pending_d;
  logic [4:0]  press;
  logic [1:0]  idx_q, idx_d;
  logic [15:0] tmo_q, tmo_d;
  logic [7:0]  data_q, data_d;
  logic [7:0]  addr_q, addr_d;
  logic        err_d;
  logic        sync_q;
  logic        sync_rise;

  logic        jam_en_q, jam_en_d;
  logic [7:0]  jam_data_q, jam_data_d;
  logic        cpu_run_q, cpu_run_d;
  logic        mem_we_q, mem_we_d;
  logic        busy_q, busy_d;

  // Index of the final jam byte for each operation.
  function automatic logic [1:0] last_idx(input op_t op);
    case (op)
      OP_RESET, OP_EXAMINE: last_idx = 2'd2;
      default:              last_idx = 2'd0;
    endcase
  endfunction

  // Byte jammed for a given operation and byte index. EXAMINE jams a JMP to
  // the switch address (low byte first), RESET a JMP to 0000.
  function automatic logic [7:0] jam_byte(input op_t op, input logic [1:0] idx,
                                          input logic [7:0] lo, input logic [7:0] hi);
    jam_byte = NOP_OP;
    if (op == OP_EXAMINE || op == OP_RESET) begin
      case (idx)
        2'd0:    jam_byte = JMP_OP;
        2'd1:    jam_byte = (op == OP_EXAMINE) ? lo : 8'h00;
        default: jam_byte = (op == OP_EXAMINE) ? hi : 8'h00;
      endcase
    end
  endfunction

  assign press     = {reset_pb, examine_pb, deposit_next_pb, examine_next_pb, deposit_pb};
  assign sync_rise = bus.cpu_sync & ~sync_q;

  always_comb begin
    // NOTE: every variable gets a default before any branch so no path leaves
    // it unassigned, which would otherwise infer a latch.
    state_d   = state_q;
    op_d      = op_q;
    idx_d     = idx_q;
    tmo_d     = '0;
    data_d    = data_q;
    addr_d    = addr_q;
    err_d     = err_q_int();
    // Presses only register while stopped. A press in its own grant cycle is
    // ORed in here and then cleared with the grant, so it merges into it.
    pending_d = pending_q | (pause ? press : 5'b0);

    if (state_q != S_IDLE && !pause) begin
      // Switching to run mid-sequence abandons it and everything queued.
      state_d   = S_IDLE;
      idx_d     = '0;
      pending_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (pause && (pending_q != 5'b0)) begin
            data_d = data_sw;
            addr_d = addr_sw;
            idx_d  = '0;
            state_d = S_JAM;
            if (pending_q[REQ_RESET]) begin
              op_d = OP_RESET;
              pending_d[REQ_RESET] = 1'b0;
              err_d = 1'b0;
            end else if (pending_q[REQ_EXAMINE]) begin
              op_d = OP_EXAMINE;
              pending_d[REQ_EXAMINE] = 1'b0;
            end else if (pending_q[REQ_DEPOSIT_NEXT]) begin
              op_d = OP_DEPOSIT_NEXT;
              pending_d[REQ_DEPOSIT_NEXT] = 1'b0;
            end else if (pending_q[REQ_EXAMINE_NEXT]) begin
              op_d = OP_EXAMINE_NEXT;
              pending_d[REQ_EXAMINE_NEXT] = 1'b0;
            end else begin
              op_d = OP_DEPOSIT;
              pending_d[REQ_DEPOSIT] = 1'b0;
              state_d = S_WRITE;
            end
          end
        end

        S_JAM: begin
          if (bus.cpu_rd) begin
            if (idx_q == last_idx(op_q)) begin
              idx_d   = '0;
              state_d = (op_q == OP_DEPOSIT_NEXT) ? S_WAIT_SYNC : S_DONE;
            end else begin
              idx_d = idx_q + 2'd1;
            end
          end else if (tmo_q == TIMEOUT) begin
            state_d = S_IDLE;
            idx_d   = '0;
            err_d   = 1'b1;
          end else begin
            tmo_d = tmo_q + 16'd1;
          end
        end

        S_WAIT_SYNC: begin
          // The NOP fetch has advanced the PC; the next SYNC edge marks the
          // address bus carrying the new address, so write it then.
          if (sync_rise) begin
            state_d = S_WRITE;
          end else if (tmo_q == TIMEOUT) begin
            state_d = S_IDLE;
            err_d   = 1'b1;
          end else begin
            tmo_d = tmo_q + 16'd1;
          end
        end

        S_WRITE: state_d = S_DONE;
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end

    jam_en_d   = (state_d == S_JAM);
    jam_data_d = (state_d == S_JAM) ? jam_byte(op_d, idx_d, data_d, addr_d) : 8'h00;
    cpu_run_d  = (state_d == S_JAM) || (state_d == S_WAIT_SYNC);
    mem_we_d   = (state_d == S_WRITE);
    busy_d     = (state_d != S_IDLE);
  end

  // err is both state and output; this keeps the comb block reading the flop.
  function automatic logic err_q_int();
    err_q_int = err;
  endfunction

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      state_q    <= S_IDLE;
      op_q       <= OP_RESET;
      pending_q  <= '0;
      idx_q      <= '0;
      tmo_q      <= '0;
      data_q     <= '0;
      addr_q     <= '0;
      err        <= 1'b0;
      sync_q     <= 1'b0;
      jam_en_q   <= 1'b0;
      jam_data_q <= '0;
      cpu_run_q  <= 1'b0;
      mem_we_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      pending_q  <= pending_d;
      idx_q      <= idx_d;
      tmo_q      <= tmo_d;
      data_q     <= data_d;
      addr_q     <= addr_d;
      err        <= err_d;
      sync_q     <= bus.cpu_sync;
      jam_en_q   <= jam_en_d;
      jam_data_q <= jam_data_d;
      cpu_run_q  <= cpu_run_d;
      mem_we_q   <= mem_we_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.jam_en    = jam_en_q;
  assign bus.jam_data  = jam_data_q;
  assign bus.cpu_run   = cpu_run_q;
  assign bus.mem_we    = mem_we_q;
  // The operand register is the write-data register: latched at grant.
  assign bus.mem_wdata = data_q;
  assign busy          = busy_q;

endmodule
